prod_bcd_disp: RTL and testbench

- Downstream stage of the 4x4 combinational multiplier.
- Captures the 8-bit product (0..225) on a valid/ready handshake.
- Converts the product to 3-digit BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives a time-multiplexed 3-digit 7-segment display on the FPGA board.

---
 rtl/prod_disp_pkg.sv | 47 ++++
 rtl/prod_bcd_disp_bin2bcd_seq.sv | 76 +++++++
 rtl/prod_bcd_disp.sv | 85 ++++++++
 tb/tb_prod_bcd_disp.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/prod_disp_pkg.sv
// prod_disp_pkg: shared definitions for the product BCD display block.
//   conv_state_t : states of the sequential binary-to-BCD converter
//   SEG_*        : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   NUM_DIGITS   : number of multiplexed display digits
//   seg_decode   : nibble to segment code; values 10..15 decode to blank
package prod_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] code;
        code = SEG_BLANK;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/prod_bcd_disp_bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 (double-dabble) converter with a
// valid/ready capture port.
//   clk, rst : clock, asynchronous active-high reset
//   p_in     : 8-bit binary value, captured when p_valid && p_ready
//   p_valid  : input present
//   p_ready  : idle and able to accept (registered)
//   busy     : conversion in progress, SHIFT or DONE (registered)
//   bcd      : last converted value {hundreds, tens, units}; held until DONE
module bin2bcd_seq
    import prod_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  p_in,
    input  logic        p_valid,
    output logic        p_ready,
    output logic        busy,
    output logic [11:0] bcd
);

    conv_state_t state;
    logic [19:0] shift_reg;
    logic [2:0]  iter;
    logic [19:0] adjusted;

    // Add-3 correction on the three BCD nibbles before each shift; the low
    // byte still holds unshifted binary bits and is passed through untouched.
    always_comb begin
        adjusted        = shift_reg;
        adjusted[11:8]  = (shift_reg[11:8]  >= 4'd5) ? shift_reg[11:8]  + 4'd3 : shift_reg[11:8];
        adjusted[15:12] = (shift_reg[15:12] >= 4'd5) ? shift_reg[15:12] + 4'd3 : shift_reg[15:12];
        adjusted[19:16] = (shift_reg[19:16] >= 4'd5) ? shift_reg[19:16] + 4'd3 : shift_reg[19:16];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            iter      <= '0;
            p_ready   <= 1'b1;
            busy      <= 1'b0;
            bcd       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (p_valid) begin
                        shift_reg <= {12'b0, p_in};
                        iter      <= '0;
                        state     <= SHIFT;
                        p_ready   <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    shift_reg <= {adjusted[18:0], 1'b0};
                    iter      <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd     <= shift_reg[19:8];
                    state   <= IDLE;
                    p_ready <= 1'b1;
                    busy    <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    p_ready <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/prod_bcd_disp.sv
// prod_bcd_disp: captures the 4x4 multiplier product, converts it to BCD and
// scans it onto a 3-digit multiplexed 7-segment display.
//   clk, rst : clock, asynchronous active-high reset
//   p_in     : 8-bit product;  p_valid / p_ready : capture handshake
//   busy     : conversion in progress
//   bcd      : last converted value {hundreds, tens, units}
//   seg      : active-low segments {g,f,e,d,c,b,a}
//   an       : active-low one-hot digit enables, an[0]=units, an[2]=hundreds
// Parameters: REFRESH_DIV (cycles per digit, >= 2), DIV_W (counter width).
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits;
// the units digit is never blanked.
module prod_bcd_disp
    import prod_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            p_in,
    input  logic                  p_valid,
    output logic                  p_ready,
    output logic                  busy,
    output logic [11:0]           bcd,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam logic [DIV_W-1:0] LAST_COUNT = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0]      refresh_cnt;
    logic [1:0]            digit_idx;
    logic [1:0]            next_idx;
    logic [3:0]            next_nibble;
    logic [6:0]            next_seg;
    logic [NUM_DIGITS-1:0] next_an;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .p_in    (p_in),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .busy    (busy),
        .bcd     (bcd)
    );

    // Everything the display will show after the next wrap is computed here,
    // so an and seg can both be registered and switch on the same edge.
    always_comb begin
        next_idx    = (digit_idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : digit_idx + 2'd1;
        next_nibble = bcd[3:0];
        unique case (next_idx)
            2'd0:    next_nibble = bcd[3:0];
            2'd1:    next_nibble = bcd[7:4];
            default: next_nibble = bcd[11:8];
        endcase
        next_seg = seg_decode(next_nibble);
`ifdef LEADING_ZERO_BLANK_EN
        if ((next_idx == 2'd2) && (bcd[11:8] == 4'd0)) begin
            next_seg = SEG_BLANK;
        end else if ((next_idx == 2'd1) && (bcd[11:4] == 8'd0)) begin
            next_seg = SEG_BLANK;
        end
`endif
        next_an = ~(NUM_DIGITS'(1) << next_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            an          <= 3'b110;
            seg         <= SEG_0;
        end else if (refresh_cnt == LAST_COUNT) begin
            refresh_cnt <= '0;
            digit_idx   <= next_idx;
            an          <= next_an;
            seg         <= next_seg;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_prod_bcd_disp.sv
// tb_prod_bcd_disp: directed bench for prod_bcd_disp with REFRESH_DIV=4.
module tb_prod_bcd_disp;

    logic        clk;
    logic        rst;
    logic [7:0]  p_in;
    logic        p_valid;
    logic        p_ready;
    logic        busy;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    prod_bcd_disp #(.REFRESH_DIV(4), .DIV_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .p_in    (p_in),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .busy    (busy),
        .bcd     (bcd),
        .seg     (seg),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Capture one value, wait (bounded) for p_ready, check latency and result.
    task automatic applyStimulus(input logic [7:0] value, input logic [11:0] expected, input string tag);
        int n;
        p_in    = value;
        p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        n = 0;
        while (!p_ready && n < 20) begin
            step();
            n++;
        end
        checkOutput({tag, "_latency"}, 16'(n), 16'd9);
        checkOutput({tag, "_bcd"}, {4'b0, bcd}, {4'b0, expected});
    endtask

    // Align to the first cycle of the units digit, then check one full scan.
    task automatic checkScan(input logic [6:0] seg_u, input logic [6:0] seg_t, input logic [6:0] seg_h, input string tag);
        int n;
        n = 0;
        while (an !== 3'b011 && n < 20) begin
            step();
            n++;
        end
        while (an !== 3'b110 && n < 20) begin
            step();
            n++;
        end
        checkOutput({tag, "_sync"}, {13'b0, an}, 16'h0006);
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin
                checkOutput({tag, "_an_u"}, {13'b0, an}, 16'h0006);
                checkOutput({tag, "_seg_u"}, {9'b0, seg}, {9'b0, seg_u});
            end else if (i < 8) begin
                checkOutput({tag, "_an_t"}, {13'b0, an}, 16'h0005);
                checkOutput({tag, "_seg_t"}, {9'b0, seg}, {9'b0, seg_t});
            end else begin
                checkOutput({tag, "_an_h"}, {13'b0, an}, 16'h0003);
                checkOutput({tag, "_seg_h"}, {9'b0, seg}, {9'b0, seg_h});
            end
            step();
        end
    endtask

    initial begin
        int n;
        int v;
        logic [11:0] exp_bcd;

        rst     = 1'b1;
        p_in    = 8'h00;
        p_valid = 1'b0;
        #12;
        checkOutput("reset_p_ready", {15'b0, p_ready}, 16'd1);
        checkOutput("reset_busy", {15'b0, busy}, 16'd0);
        checkOutput("reset_bcd", {4'b0, bcd}, 16'h0000);
        checkOutput("reset_an", {13'b0, an}, 16'h0006);
        checkOutput("reset_seg", {9'b0, seg}, {9'b0, S0});
        #1 rst = 1'b0;
        step();

        $display("[TB] 15*15 latency and busy profile");
        p_in    = 8'hE1;
        p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checkOutput("e1_busy_ready", {14'b0, busy, p_ready}, 16'b10);
            checkOutput("e1_bcd_hold", {4'b0, bcd}, 16'h0000);
            step();
        end
        checkOutput("e1_bcd", {4'b0, bcd}, 16'h0225);
        checkOutput("e1_ready", {14'b0, busy, p_ready}, 16'b01);

        $display("[TB] zero and ten");
        applyStimulus(8'h00, 12'h000, "zero");
`ifdef LEADING_ZERO_BLANK_EN
        checkScan(S0, SB, SB, "scan000");
`else
        checkScan(S0, S0, S0, "scan000");
`endif
        applyStimulus(8'h0A, 12'h010, "ten");
`ifdef LEADING_ZERO_BLANK_EN
        checkScan(S0, S1, SB, "scan010");
`else
        checkScan(S0, S1, S0, "scan010");
`endif

        $display("[TB] p_valid held high across a conversion");
        p_in    = 8'h31;
        p_valid = 1'b1;
        step();
        step();
        step();
        step();
        p_in = 8'h64;
        n = 3;
        while (!p_ready && n < 20) begin
            step();
            n++;
        end
        checkOutput("held_latency", 16'(n), 16'd9);
        checkOutput("held_bcd_49", {4'b0, bcd}, 16'h0049);
        step();
        checkOutput("held_recapture", {14'b0, busy, p_ready}, 16'b10);
        p_valid = 1'b0;
        n = 0;
        while (!p_ready && n < 20) begin
            step();
            n++;
        end
        checkOutput("held2_latency", 16'(n), 16'd9);
        checkOutput("held_bcd_100", {4'b0, bcd}, 16'h0100);

        $display("[TB] scan of 196");
        applyStimulus(8'hC4, 12'h196, "v196");
        checkScan(S6, S9, S1, "scan196");

        $display("[TB] reset mid-conversion");
        p_in    = 8'hE1;
        p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        step();
        step();
        step();
        step();
        checkOutput("mid_busy", {15'b0, busy}, 16'd1);
        #3 rst = 1'b1;
        #1;
        checkOutput("mid_rst_p_ready", {15'b0, p_ready}, 16'd1);
        checkOutput("mid_rst_busy", {15'b0, busy}, 16'd0);
        checkOutput("mid_rst_bcd", {4'b0, bcd}, 16'h0000);
        checkOutput("mid_rst_an", {13'b0, an}, 16'h0006);
        checkOutput("mid_rst_seg", {9'b0, seg}, {9'b0, S0});
        #2 rst = 1'b0;
        step();
        applyStimulus(8'h51, 12'h081, "after_rst");

        $display("[TB] product sweep");
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                v = x * y;
                exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
                applyStimulus(8'(v), exp_bcd, $sformatf("sweep_%0dx%0d", x, y));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
